// File: rtl/wb_write_port_if.sv
// wb_write_port_if
// Groups the bus signals of the writeback stage: the MEM-stage inputs, the
// pipeline controls, the MDU handshake, the register-file write port and the
// decode-stage bypass. Clock and reset stay plain ports on the module.
//   master : the environment side (drives MEM/MDU/read-port inputs)
//   slave  : the writeback stage itself
interface wb_write_port_if;
  logic        mem_valid;
  logic        mem_RegWrite;
  logic        mem_MemtoReg;
  logic        mem_Link;
  logic [4:0]  mem_dest;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_read_data;
  logic [31:0] mem_pc_plus4;
  logic        stall;
  logic        flush;
  logic        mdu_valid;
  logic [4:0]  mdu_dest;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        wb_stall_req;
  logic [4:0]  Write_Reg_Num;
  logic [31:0] Write_Data;
  logic        RegWrite;
  logic [4:0]  Read_Reg_Num_1;
  logic [4:0]  Read_Reg_Num_2;
  logic [31:0] Read_Data_1;
  logic [31:0] Read_Data_2;
  logic [31:0] fwd_Data_1;
  logic [31:0] fwd_Data_2;

  modport master (
    output mem_valid, mem_RegWrite, mem_MemtoReg, mem_Link, mem_dest,
    output mem_alu_result, mem_read_data, mem_pc_plus4, stall, flush,
    output mdu_valid, mdu_dest, mdu_data,
    output Read_Reg_Num_1, Read_Reg_Num_2, Read_Data_1, Read_Data_2,
    input  mdu_ready, wb_stall_req, Write_Reg_Num, Write_Data, RegWrite,
    input  fwd_Data_1, fwd_Data_2
  );

  modport slave (
    input  mem_valid, mem_RegWrite, mem_MemtoReg, mem_Link, mem_dest,
    input  mem_alu_result, mem_read_data, mem_pc_plus4, stall, flush,
    input  mdu_valid, mdu_dest, mdu_data,
    input  Read_Reg_Num_1, Read_Reg_Num_2, Read_Data_1, Read_Data_2,
    output mdu_ready, wb_stall_req, Write_Reg_Num, Write_Data, RegWrite,
    output fwd_Data_1, fwd_Data_2
  );
endinterface

// File: rtl/wb_write_port.sv
// wb_write_port
// Writeback stage of the MIPS pipeline and owner of the single register-file
// write port. Holds the MEM/WB register, merges multiply/divide results via a
// 2-entry FIFO, and bypasses the write-port value to the two decode reads.
// Ports:
//   clk   : core clock, all state changes on posedge
//   reset : synchronous, active-low
//   bus   : wb_write_port_if.slave (MEM inputs, MDU handshake, write port,
//           decode read addresses/data and bypassed operands)
module wb_write_port #(
  parameter int QDEPTH = 2
) (
  input logic             clk,
  input logic             reset,
  wb_write_port_if.slave  bus
);

  logic        wb_valid_q;
  logic        wb_regwrite_q;
  logic        wb_done_q;
  logic [4:0]  wb_dest_q;
  logic [31:0] wb_value_q;

  logic [1:0]  count_q, count_d;
  logic        head_q, head_d;
  logic [4:0]  q_dest_q [2];
  logic [31:0] q_data_q [2];

  logic        wb_pend;
  logic        drain;
  logic        accept;
  logic        enq;
  logic        keep0, keep1;
  logic [1:0]  kept;
  logic        wr_slot;
  logic [31:0] mem_value;

  assign mem_value = bus.mem_Link     ? bus.mem_pc_plus4  :
                     bus.mem_MemtoReg ? bus.mem_read_data :
                                        bus.mem_alu_result;

  // Gated by reset so nothing reaches the register file while reset is held.
  assign wb_pend = reset && wb_valid_q && wb_regwrite_q &&
                   (wb_dest_q != 5'd0) && !wb_done_q;
  assign drain   = reset && !wb_pend && (count_q != 2'd0);

  assign bus.mdu_ready    = reset && (count_q < 2'(QDEPTH));
  assign bus.wb_stall_req = (count_q == 2'(QDEPTH));

  assign accept = bus.mdu_valid && bus.mdu_ready;
  // r0 results are acknowledged but never stored.
  assign enq    = accept && (bus.mdu_dest != 5'd0);

  // Queue update: first remove the drained head and any entries overwritten by
  // the committing WB write, compacting survivors toward the head; then append
  // the accepted entry behind the survivors.
  always_comb begin
    keep0 = (count_q != 2'd0) && !drain &&
            !(wb_pend && (q_dest_q[head_q] == wb_dest_q));
    keep1 = (count_q == 2'd2) &&
            !(wb_pend && (q_dest_q[~head_q] == wb_dest_q));
    head_d  = (keep0 || (count_q == 2'd0)) ? head_q : ~head_q;
    kept    = {1'b0, keep0} + {1'b0, keep1};
    wr_slot = head_d ^ kept[0];
    count_d = kept + {1'b0, enq};
  end

  always_comb begin
    bus.RegWrite      = 1'b0;
    bus.Write_Reg_Num = 5'd0;
    bus.Write_Data    = 32'd0;
    if (wb_pend) begin
      bus.RegWrite      = 1'b1;
      bus.Write_Reg_Num = wb_dest_q;
      bus.Write_Data    = wb_value_q;
    end else if (drain) begin
      bus.RegWrite      = 1'b1;
      bus.Write_Reg_Num = q_dest_q[head_q];
      bus.Write_Data    = q_data_q[head_q];
    end
  end

  // The register file commits on the edge, so its same-cycle read is stale.
  assign bus.fwd_Data_1 = (bus.RegWrite && (bus.Write_Reg_Num == bus.Read_Reg_Num_1) &&
                           (bus.Read_Reg_Num_1 != 5'd0)) ? bus.Write_Data : bus.Read_Data_1;
  assign bus.fwd_Data_2 = (bus.RegWrite && (bus.Write_Reg_Num == bus.Read_Reg_Num_2) &&
                           (bus.Read_Reg_Num_2 != 5'd0)) ? bus.Write_Data : bus.Read_Data_2;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wb_valid_q <= 1'b0;
      wb_done_q  <= 1'b0;
      count_q    <= 2'd0;
      head_q     <= 1'b0;
    end else begin
      if (bus.flush) begin
        wb_valid_q <= 1'b0;
        wb_done_q  <= 1'b0;
      end else if (!bus.stall) begin
        wb_valid_q    <= bus.mem_valid;
        wb_regwrite_q <= bus.mem_RegWrite;
        wb_dest_q     <= bus.mem_dest;
        wb_value_q    <= mem_value;
        wb_done_q     <= 1'b0;
      end else if (wb_pend) begin
        // A stalled instruction keeps its slot but must write only once.
        wb_done_q <= 1'b1;
      end

      count_q <= count_d;
      head_q  <= head_d;
      if (enq) begin
        q_dest_q[wr_slot] <= bus.mdu_dest;
        q_data_q[wr_slot] <= bus.mdu_data;
      end
    end
  end

endmodule
